// File: rtl/or1200_keccak_ctrl_pkg.sv
// Shared definitions for the OR1200 Keccak-f[1600] coprocessor sequencer:
// op encodings, FSM states, state geometry and the writeback select code.
package or1200_keccak_defs;

    localparam int NUM_ROUNDS = 24;
    localparam int NUM_WORDS  = 50;
    localparam int IDX_W      = 6;
    localparam int RND_W      = 5;

    localparam logic [IDX_W-1:0] WORDS_LIMIT = IDX_W'(NUM_WORDS);
    localparam logic [RND_W-1:0] LAST_ROUND  = RND_W'(NUM_ROUNDS - 1);

    // rfwb_op value that steers the writeback mux to keccak_dataout
    localparam logic [3:0] RFWBOP_KECCAK = 4'b1111;

    typedef enum logic [1:0] {
        KOP_NOP     = 2'b00,
        KOP_ABSORB  = 2'b01,
        KOP_PERMUTE = 2'b10,
        KOP_SQUEEZE = 2'b11
    } kop_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_PERM_GO,
        ST_PERM_WAIT
    } state_e;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return idx < WORDS_LIMIT;
    endfunction

endpackage

// File: rtl/or1200_keccak_rndcnt.sv
// Round counter for PERMUTE: clears on load, steps on inc, flags the final round.
module or1200_keccak_rndcnt
    import or1200_keccak_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [RND_W-1:0] cnt,
    output logic             last
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + RND_W'(1);
        end
    end

    assign last = (cnt == LAST_ROUND);

endmodule

// File: rtl/or1200_keccak_ctrl.sv
// Keccak coprocessor sequencer: decodes ABSORB/PERMUTE/SQUEEZE from EX, drives
// the round core, stalls the pipeline on multi-cycle ops and registers the result.
module or1200_keccak_ctrl
    import or1200_keccak_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_freeze,
    input  logic             wb_freeze,
    input  logic [1:0]       kop,
    input  logic [IDX_W-1:0] kop_idx,
    input  logic [31:0]      kop_data,
    output logic             core_wr_en,
    output logic [IDX_W-1:0] core_wr_idx,
    output logic [31:0]      core_wr_data,
    output logic [IDX_W-1:0] core_rd_idx,
    input  logic [31:0]      core_rd_data,
    output logic             core_round_go,
    output logic [RND_W-1:0] core_round_idx,
    input  logic             core_round_done,
    output logic             keccak_stall,
    output logic [31:0]      keccak_dataout,
    output logic             keccak_valid,
    output logic             keccak_err
);

    state_e state;
    kop_e   op;
    logic   accept;
    logic   sq_oor;
    logic   cnt_load;
    logic   cnt_inc;
    logic   cnt_last;

    assign op       = kop_e'(kop);
    assign accept   = (state == ST_IDLE) && !ex_freeze && (op != KOP_NOP);
    assign cnt_load = accept && (op == KOP_PERMUTE);
    assign cnt_inc  = (state == ST_PERM_WAIT) && core_round_done && !cnt_last;

    // The counter register drives core_round_idx directly, so it always
    // matches the round whose go pulse is currently on the wire.
    or1200_keccak_rndcnt u_rndcnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .inc  (cnt_inc),
        .cnt  (core_round_idx),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control and output registers exist here; the Keccak
            // state lives in the core and deliberately survives this reset.
            state          <= ST_IDLE;
            sq_oor         <= 1'b0;
            core_wr_en     <= 1'b0;
            core_wr_idx    <= '0;
            core_wr_data   <= '0;
            core_rd_idx    <= '0;
            core_round_go  <= 1'b0;
            keccak_stall   <= 1'b0;
            keccak_dataout <= '0;
            keccak_valid   <= 1'b0;
            keccak_err     <= 1'b0;
        end else begin
            core_wr_en    <= 1'b0;
            core_round_go <= 1'b0;
            if (!wb_freeze) begin
                keccak_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            KOP_ABSORB: begin
                                if (idx_in_range(kop_idx)) begin
                                    core_wr_en   <= 1'b1;
                                    core_wr_idx  <= kop_idx;
                                    core_wr_data <= kop_data;
                                end else begin
                                    keccak_err <= 1'b1;
                                end
                            end
                            KOP_SQUEEZE: begin
                                state        <= ST_RD_WAIT;
                                keccak_stall <= 1'b1;
                                if (idx_in_range(kop_idx)) begin
                                    core_rd_idx <= kop_idx;
                                    sq_oor      <= 1'b0;
                                end else begin
                                    sq_oor     <= 1'b1;
                                    keccak_err <= 1'b1;
                                end
                            end
                            KOP_PERMUTE: begin
                                // Round 0 launches on entry, alongside the counter clear.
                                state         <= ST_PERM_GO;
                                keccak_stall  <= 1'b1;
                                core_round_go <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_RD_WAIT: state <= ST_RD_CAP;

                ST_RD_CAP: begin
                    // A frozen WB still owns the previous result; hold until it drains.
                    if (!wb_freeze) begin
                        keccak_dataout <= sq_oor ? 32'h0 : core_rd_data;
                        keccak_valid   <= 1'b1;
                        keccak_stall   <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end

                ST_PERM_GO: state <= ST_PERM_WAIT;

                ST_PERM_WAIT: begin
                    if (core_round_done) begin
                        if (cnt_last) begin
                            keccak_stall <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            core_round_go <= 1'b1;
                            state         <= ST_PERM_GO;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or1200_keccak_ctrl.sv
// Self-checking bench for or1200_keccak_ctrl: behavioural round core plus an
// op-level reference of the 1600-bit state, directed steps then random ops.
module tb_or1200_keccak_ctrl;
    import or1200_keccak_defs::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ex_freeze = 1'b0;
    logic             wb_freeze = 1'b0;
    logic [1:0]       kop = 2'b00;
    logic [IDX_W-1:0] kop_idx = '0;
    logic [31:0]      kop_data = '0;
    logic             core_wr_en;
    logic [IDX_W-1:0] core_wr_idx;
    logic [31:0]      core_wr_data;
    logic [IDX_W-1:0] core_rd_idx;
    logic [31:0]      core_rd_data = '0;
    logic             core_round_go;
    logic [RND_W-1:0] core_round_idx;
    logic             core_round_done = 1'b0;
    logic             keccak_stall;
    logic [31:0]      keccak_dataout;
    logic             keccak_valid;
    logic             keccak_err;

    logic             inject_done = 1'b0;
    logic [31:0]      core_mem [NUM_WORDS] = '{default: 32'h0};
    logic [31:0]      ref_mem  [NUM_WORDS] = '{default: 32'h0};
    logic             ref_err = 1'b0;
    int               go_q[$];
    int               checks = 0;
    int               failures = 0;

    or1200_keccak_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ex_freeze       (ex_freeze),
        .wb_freeze       (wb_freeze),
        .kop             (kop),
        .kop_idx         (kop_idx),
        .kop_data        (kop_data),
        .core_wr_en      (core_wr_en),
        .core_wr_idx     (core_wr_idx),
        .core_wr_data    (core_wr_data),
        .core_rd_idx     (core_rd_idx),
        .core_rd_data    (core_rd_data),
        .core_round_go   (core_round_go),
        .core_round_idx  (core_round_idx),
        .core_round_done (core_round_done),
        .keccak_stall    (keccak_stall),
        .keccak_dataout  (keccak_dataout),
        .keccak_valid    (keccak_valid),
        .keccak_err      (keccak_err)
    );

    always #5 clk = ~clk;

    // Toy round function standing in for Keccak-f; only its determinism matters.
    function automatic logic [31:0] round_fn(input logic [31:0] w, input int wi, input int r);
        return {w[30:0], w[31]} ^ (32'(r) * 32'h0100_0193) ^ 32'(wi);
    endfunction

    // Behavioural core: XOR writes, registered reads, done one cycle after go.
    always @(posedge clk) begin
        core_round_done <= core_round_go | inject_done;
        core_rd_data    <= (int'(core_rd_idx) < NUM_WORDS) ? core_mem[core_rd_idx] : 32'hBAD0_BAD0;
        if (core_wr_en)
            core_mem[core_wr_idx] <= core_mem[core_wr_idx] ^ core_wr_data;
        if (core_round_go)
            for (int w = 0; w < NUM_WORDS; w++)
                core_mem[w] <= round_fn(core_mem[w], w, int'(core_round_idx));
    end

    always @(negedge clk)
        if (!rst && core_round_go) go_q.push_back(int'(core_round_idx));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [IDX_W-1:0] idx,
                         input logic [31:0] data, input logic frz);
        kop       = op;
        kop_idx   = idx;
        kop_data  = data;
        ex_freeze = frz;
        tick();
        kop       = KOP_NOP;
        ex_freeze = 1'b0;
    endtask

    function automatic logic [IDX_W-1:0] rand_idx();
        if ($urandom_range(0, 9) == 0) return IDX_W'($urandom_range(NUM_WORDS, 63));
        return IDX_W'($urandom_range(0, NUM_WORDS - 1));
    endfunction

    task automatic do_absorb(input logic [IDX_W-1:0] idx, input logic [31:0] data);
        logic ok;
        ok = int'(idx) < NUM_WORDS;
        issue(KOP_ABSORB, idx, data, 1'b0);
        check("absorb_wr_en", 32'(core_wr_en), 32'(ok));
        if (ok) begin
            check("absorb_wr_idx", 32'(core_wr_idx), 32'(idx));
            check("absorb_wr_data", core_wr_data, data);
            ref_mem[idx] = ref_mem[idx] ^ data;
        end else begin
            ref_err = 1'b1;
        end
        check("absorb_no_stall", 32'(keccak_stall), 0);
        check("absorb_err", 32'(keccak_err), 32'(ref_err));
        tick();
        check("absorb_wr_pulse", 32'(core_wr_en), 0);
    endtask

    task automatic do_squeeze(input logic [IDX_W-1:0] idx);
        logic             ok;
        logic [31:0]      exp;
        logic [IDX_W-1:0] rd_before;
        int               n;
        int               stall_cnt;
        ok        = int'(idx) < NUM_WORDS;
        exp       = ok ? ref_mem[idx] : 32'h0;
        rd_before = core_rd_idx;
        if (!ok) ref_err = 1'b1;
        issue(KOP_SQUEEZE, idx, 32'h0, 1'b0);
        n = 0;
        stall_cnt = 0;
        while (keccak_valid !== 1'b1 && n < 20) begin
            if (keccak_stall) stall_cnt++;
            tick();
            n++;
        end
        check("sq_valid", 32'(keccak_valid), 1);
        check("sq_data", keccak_dataout, exp);
        check("sq_latency", 32'(n), 2);
        check("sq_stall_len", 32'(stall_cnt), 2);
        check("sq_stall_drop", 32'(keccak_stall), 0);
        check("sq_err", 32'(keccak_err), 32'(ref_err));
        if (!ok) check("sq_oor_no_read", 32'(core_rd_idx), 32'(rd_before));
        tick();
        check("sq_valid_pulse", 32'(keccak_valid), 0);
    endtask

    task automatic do_permute();
        int n;
        int stall_cnt;
        logic valid_seen;
        go_q.delete();
        issue(KOP_PERMUTE, '0, 32'h0, 1'b0);
        n = 0;
        stall_cnt = 0;
        valid_seen = 1'b0;
        while (keccak_stall === 1'b1 && n < 200) begin
            stall_cnt++;
            if (keccak_valid) valid_seen = 1'b1;
            tick();
            n++;
        end
        check("perm_stall_len", 32'(stall_cnt), 32'(2 * NUM_ROUNDS));
        check("perm_go_count", 32'(go_q.size()), 32'(NUM_ROUNDS));
        for (int i = 0; i < go_q.size() && i < NUM_ROUNDS; i++)
            check("perm_round_idx", 32'(go_q[i]), 32'(i));
        check("perm_no_valid", 32'(valid_seen), 0);
        for (int r = 0; r < NUM_ROUNDS; r++)
            for (int w = 0; w < NUM_WORDS; w++)
                ref_mem[w] = round_fn(ref_mem[w], w, r);
    endtask

    initial begin
        logic [31:0] exp;
        int          n;

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        check("rst_wr_en", 32'(core_wr_en), 0);
        check("rst_wr_idx", 32'(core_wr_idx), 0);
        check("rst_wr_data", core_wr_data, 0);
        check("rst_rd_idx", 32'(core_rd_idx), 0);
        check("rst_round_go", 32'(core_round_go), 0);
        check("rst_round_idx", 32'(core_round_idx), 0);
        check("rst_stall", 32'(keccak_stall), 0);
        check("rst_dataout", keccak_dataout, 0);
        check("rst_valid", 32'(keccak_valid), 0);
        check("rst_err", 32'(keccak_err), 0);

        // Directed ABSORB / SQUEEZE / PERMUTE
        do_absorb(6'd5, 32'hDEAD_BEEF);
        do_absorb(6'd7, 32'h1234_5678);
        do_squeeze(6'd7);
        check("sq7_value", keccak_dataout, 32'h1234_5678);
        do_permute();
        do_squeeze(6'd5);

        // ex_freeze blocks acceptance
        issue(KOP_ABSORB, 6'd1, 32'hFFFF_0000, 1'b1);
        check("exfrz_no_wr", 32'(core_wr_en), 0);
        issue(KOP_SQUEEZE, 6'd1, 32'h0, 1'b1);
        check("exfrz_no_stall", 32'(keccak_stall), 0);
        issue(KOP_PERMUTE, 6'd0, 32'h0, 1'b1);
        check("exfrz_no_go", 32'(core_round_go), 0);

        // Out-of-range index: SQUEEZE 50, then ABSORB 63, then a good ABSORB
        do_squeeze(6'd50);
        check("oor_dataout_zero", keccak_dataout, 0);
        do_absorb(6'd63, 32'hAAAA_5555);
        do_absorb(6'd49, 32'h0F0F_0F0F);
        check("oor_err_sticky", 32'(keccak_err), 1);

        // wb_freeze holds a completed result; a stray round_done in IDLE is ignored
        go_q.delete();
        exp = ref_mem[3];
        issue(KOP_SQUEEZE, 6'd3, 32'h0, 1'b0);
        tick();
        tick();
        check("frz_valid", 32'(keccak_valid), 1);
        check("frz_data", keccak_dataout, exp);
        wb_freeze   = 1'b1;
        inject_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            inject_done = 1'b0;
            check("frz_valid_hold", 32'(keccak_valid), 1);
            check("frz_data_hold", keccak_dataout, exp);
            check("frz_idle_no_stall", 32'(keccak_stall), 0);
        end
        check("late_done_no_go", 32'(go_q.size()), 0);
        wb_freeze = 1'b0;
        tick();
        check("frz_release", 32'(keccak_valid), 0);

        // SQUEEZE issued while WB is frozen waits in capture with the stall held
        wb_freeze = 1'b1;
        exp = ref_mem[9];
        issue(KOP_SQUEEZE, 6'd9, 32'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check("frzsq_stall", 32'(keccak_stall), 1);
            check("frzsq_no_valid", 32'(keccak_valid), 0);
            tick();
        end
        wb_freeze = 1'b0;
        tick();
        check("frzsq_valid", 32'(keccak_valid), 1);
        check("frzsq_data", keccak_dataout, exp);
        check("frzsq_stall_drop", 32'(keccak_stall), 0);
        tick();

        // Random op mix against the op-level reference
        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                do_absorb(rand_idx(), $urandom);
            end else if (sel <= 6) begin
                do_squeeze(rand_idx());
            end else if (sel == 7) begin
                do_permute();
            end else if (sel == 8) begin
                issue(2'($urandom_range(1, 3)), rand_idx(), $urandom, 1'b1);
                check("rnd_exfrz_wr", 32'(core_wr_en), 0);
                check("rnd_exfrz_stall", 32'(keccak_stall), 0);
                check("rnd_exfrz_err", 32'(keccak_err), 32'(ref_err));
            end else begin
                tick();
                check("rnd_idle_stall", 32'(keccak_stall), 0);
            end
        end

        // Read back the whole state
        for (int w = 0; w < NUM_WORDS; w++)
            do_squeeze(IDX_W'(w));

        // Reset during round 10, then a fresh PERMUTE restarts at round 0
        go_q.delete();
        issue(KOP_PERMUTE, '0, 32'h0, 1'b0);
        n = 0;
        while (go_q.size() < 11 && n < 100) begin
            tick();
            n++;
        end
        check("midrst_reached_r10", 32'(go_q.size() >= 11), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_err = 1'b0;
        check("midrst_stall", 32'(keccak_stall), 0);
        check("midrst_go", 32'(core_round_go), 0);
        check("midrst_round_idx", 32'(core_round_idx), 0);
        check("midrst_err", 32'(keccak_err), 0);
        check("midrst_valid", 32'(keccak_valid), 0);
        repeat (2) tick();
        check("midrst_idle", 32'(keccak_stall), 0);
        do_permute();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or1200_keccak_ctrl.md
Name: or1200_keccak_ctrl

Overview:
- Sequencer for the Keccak-f[1600] coprocessor attached to the OR1200 pipeline.
- Decodes keccak instructions issued from EX: ABSORB, PERMUTE and SQUEEZE.
- Drives the external round core (lane write, lane read, round stepping) and raises a pipeline stall while multi-cycle ops run.
- Presents a registered 32-bit result plus valid to the writeback mux on its keccak input, which is selected when rfwb_op = 1111.

Parameters:
- NUM_ROUNDS, 24, permutation rounds per PERMUTE.
- NUM_WORDS, 50, 32-bit words in the 1600-bit state.
- IDX_W, 6, word index width.
- RND_W, 5, round index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_freeze  in  1  EX stage frozen; a new op is not accepted.
- wb_freeze  in  1  WB stage frozen; result register holds.
- kop  in  2  op: 00 NOP, 01 ABSORB, 10 PERMUTE, 11 SQUEEZE.
- kop_idx  in  IDX_W  word index for ABSORB/SQUEEZE.
- kop_data  in  32  operand for ABSORB.
- core_wr_en  out  1  one-cycle XOR-write strobe to the core.
- core_wr_idx  out  IDX_W  write word index.
- core_wr_data  out  32  write data.
- core_rd_idx  out  IDX_W  read word index; core returns data one cycle later.
- core_rd_data  in  32  registered read data from the core.
- core_round_go  out  1  one-cycle pulse that starts one round.
- core_round_idx  out  RND_W  round constant index, 0..NUM_ROUNDS-1.
- core_round_done  in  1  round complete pulse.
- keccak_stall  out  1  freeze request to the pipeline.
- keccak_dataout  out  32  result to the wbmux keccak input.
- keccak_valid  out  1  keccak_dataout is valid for writeback.
- keccak_err  out  1  sticky: index out of range.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, round counter 0.
  - keccak_err cleared.
- Reset mid-operation returns to IDLE next edge and drops the stall. The core state is not cleared by this block.
- FSM states: IDLE, RD_WAIT, RD_CAP, PERM_GO, PERM_WAIT.
- An op is accepted only in IDLE with ex_freeze=0 and kop!=00.
- IDLE + ABSORB:
  - Valid index: core_wr_en=1 for exactly the next cycle, with idx and data registered.
  - No stall; stays in IDLE; keccak_valid unchanged.
- IDLE + SQUEEZE:
  - Register core_rd_idx, go to RD_WAIT, assert keccak_stall.
  - RD_WAIT -> RD_CAP. RD_CAP captures core_rd_data into keccak_dataout, pulses keccak_valid, drops the stall, returns to IDLE.
  - Issue to valid is 3 cycles; the stall is 2 cycles.
- IDLE + PERMUTE:
  - Round counter <= 0, go to PERM_GO, assert keccak_stall.
  - PERM_GO: core_round_go=1 for one cycle with core_round_idx=counter, then PERM_WAIT.
  - PERM_WAIT on core_round_done: if counter==NUM_ROUNDS-1, go to IDLE and drop the stall; else increment counter and go to PERM_GO.
  - core_round_done in any other state is ignored.
  - Stall lasts at least 2*NUM_ROUNDS cycles. keccak_valid is not asserted; PERMUTE has no writeback.
- Index >= NUM_WORDS on ABSORB/SQUEEZE:
  - No core access.
  - keccak_err set (cleared only by rst).
  - SQUEEZE still completes with keccak_dataout=0 and valid, so writeback is not lost.
- keccak_valid is a single-cycle pulse unless wb_freeze=1. While wb_freeze=1, keccak_dataout and keccak_valid hold their values, and completion of a new SQUEEZE waits in RD_CAP with the stall held.
- While busy, kop is ignored. The pipeline is frozen by keccak_stall and re-presents the op afterward; re-presentation is a new issue only if ex_freeze=0 in IDLE.
- ex_freeze=1 in IDLE: no op accepted, no outputs change.

Decomposition:
- Shared package or1200_keccak_defs:
  - kop encodings KOP_NOP/ABSORB/PERMUTE/SQUEEZE.
  - FSM state encodings.
  - NUM_ROUNDS and NUM_WORDS constants.
  - The RFWBOP keccak select value 1111.
- One natural sub-module, or1200_keccak_rndcnt: round counter with load, increment and terminal flag.
- Everything else lives in the single FSM.

Test Plan:
- ABSORB: kop=01, idx=5, data=32'hDEADBEEF -> next cycle core_wr_en=1, core_wr_idx=5, core_wr_data=DEADBEEF; keccak_stall never asserts.
- SQUEEZE: idx=7, core models rd_data=32'h12345678 -> stall high 2 cycles; keccak_valid pulse 1 cycle with dataout=12345678 at cycle 3.
- PERMUTE: core returns round_done 1 cycle after each go -> 24 go pulses, core_round_idx 0..23 in order; stall drops after the done for round 23; stall length 48 cycles.
- Out of range: SQUEEZE idx=50 -> no core read; keccak_err=1; keccak_valid with dataout=0. A subsequent valid ABSORB works and keccak_err stays 1.
- Reset mid-permute: rst=1 for 1 cycle during round 10 -> next cycle stall=0, FSM IDLE; a new PERMUTE restarts at round_idx 0.
- wb_freeze: SQUEEZE completes while wb_freeze=1 for 4 cycles -> keccak_valid and dataout hold 4 cycles; a late round_done in IDLE has no effect.
